uart_xmtr: RTL and testbench

//  Serial UART transmitter: the stimulus stage that drives the DUT's UART RX
//  pin (uart_sin), the counterpart of uart_rcvr, which captures the DUT's TX.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_xmtr_fifo.sv | 51 +++++
 rtl/uart_xmtr.sv | 121 ++++++++++++
 tb/tb_uart_xmtr.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding and frame constants for uart_xmtr and uart_rcvr.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   BIT_IDX_W  = $clog2(DATA_BITS);
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic is_last_data_bit(input logic [BIT_IDX_W-1:0] idx);
        return idx == BIT_IDX_W'(DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/uart_xmtr_fifo.sv
// Synchronous byte FIFO feeding the transmitter shifter; full pushes are dropped.
module uart_xmtr_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers are PTR_W wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_xmtr.sv
// 8N1 UART transmitter: buffered byte input, registered serial line, contiguous frames.
module uart_xmtr
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 868,
    parameter  int FIFO_DEPTH   = 16,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] char_in,
    input  logic                 char_valid,
    output logic                 char_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_t            state, state_nxt;
    logic [BAUD_W-1:0]      baud_cnt, baud_nxt;
    logic [BIT_IDX_W-1:0]   bit_idx, bit_nxt;
    logic [DATA_BITS-1:0]   shift_reg, shift_nxt;
    logic                   line_nxt;
    logic                   baud_last;
    logic                   pop;
    logic                   fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;

    uart_xmtr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (char_valid),
        .din   (char_in),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign char_ready = ~fifo_full;
    assign busy       = (state != ST_IDLE) | ~fifo_empty;
    assign baud_last  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            serial_out <= IDLE_LEVEL;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= bit_nxt;
            shift_reg  <= shift_nxt;
            serial_out <= line_nxt;
        end
    end

    // Every state exit happens on baud_last, so the wrap to 0 doubles as the
    // restart-on-entry; IDLE pins the counter at 0 for the IDLE->START case.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_last ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_head;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    bit_nxt   = '0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_nxt = shift_reg >> 1;
                    if (is_last_data_bit(bit_idx)) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_head;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line level is derived from the next state so serial_out is a clean register.
    always_comb begin
        case (state_nxt)
            ST_START: line_nxt = START_BIT;
            ST_DATA:  line_nxt = shift_nxt[0];
            ST_STOP:  line_nxt = STOP_BIT;
            default:  line_nxt = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_xmtr.sv
// Scoreboard bench for uart_xmtr: accepted bytes are queued, a line decoder pops and compares.
module tb_uart_xmtr;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       serial_out;
    logic       busy;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    logic [7:0] exp_q [$];
    logic       mon_bits [$];
    bit         mon_active = 1'b0;

    uart_xmtr #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level i cycles into a run of frames carrying b0 then b1.
    function automatic logic wave_bit(input logic [7:0] b0, input logic [7:0] b1, input int i);
        int f, b;
        logic [7:0] d;
        f = i / FRAME;
        b = (i % FRAME) / CPB;
        d = (f == 0) ? b0 : b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    // Handshake-level acceptance: every transferred byte is owed one frame.
    always @(posedge clock) begin
        if (reset && char_valid && char_ready) begin
            exp_q.push_back(char_in);
            n_acc++;
        end
    end

    // Line decoder: a frame is 10 bit periods, each held constant for CPB cycles.
    always @(negedge clock) begin
        if (!reset) begin
            mon_active = 1'b0;
            mon_bits.delete();
        end else begin
            if (!mon_active && serial_out === 1'b0) mon_active = 1'b1;
            if (mon_active) begin
                mon_bits.push_back(serial_out);
                if (mon_bits.size() == FRAME) begin
                    int bad;
                    logic [7:0] got;
                    bad = 0;
                    got = '0;
                    for (int b = 0; b < 10; b++) begin
                        for (int k = 1; k < CPB; k++)
                            if (mon_bits[b*CPB+k] !== mon_bits[b*CPB]) bad++;
                        if (b >= 1 && b <= 8) got[b-1] = mon_bits[b*CPB];
                    end
                    if (mon_bits[0] !== 1'b0) bad++;
                    if (mon_bits[9*CPB] !== 1'b1) bad++;
                    check("frame_shape", bad, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", got);
                    end else begin
                        check("frame_data", got, exp_q.pop_front());
                    end
                    mon_active = 1'b0;
                    mon_bits.delete();
                end
            end
        end
    end

    // Presents b until accepted; returns at the negedge just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clock);
        char_valid = 1'b1;
        char_in    = b;
        t = 0;
        while (!char_ready && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 1000) check("send_timeout", 1, 0);
        @(negedge clock);
        char_valid = 1'b0;
        char_in    = $urandom_range(0, 255);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check(name, (t < 3000) ? 1 : 0, 1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int acc0;
        string msg;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_serial_out", serial_out, 1);
        check("rst_char_ready", char_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single byte: exact waveform and busy drop
        send_byte(8'h55);
        check("single_latency", serial_out, 1);
        mism = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            if (serial_out !== wave_bit(8'h55, 8'h00, i)) mism++;
        end
        check("single_wave", mism, 0);
        check("single_busy_stop", busy, 1);
        @(negedge clock);
        check("single_busy_done", busy, 0);
        check("single_line_idle", serial_out, 1);

        // Back-to-back: two frames with no idle gap
        @(negedge clock);
        char_valid = 1'b1;
        char_in    = 8'h48;
        @(negedge clock);
        check("b2b_latency", serial_out, 1);
        char_in = 8'h69;
        @(negedge clock);
        char_valid = 1'b0;
        mism = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i > 0) @(negedge clock);
            if (serial_out !== wave_bit(8'h48, 8'h69, i)) mism++;
        end
        check("b2b_wave", mism, 0);
        wait_idle("b2b_idle");

        // Fill: 16 in the FIFO plus 1 in the shifter
        acc0 = n_acc;
        @(negedge clock);
        char_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            char_in = 8'(n_acc - acc0);
            @(negedge clock);
        end
        check("fill_accepted", n_acc - acc0, 17);
        check("fill_ready", char_ready, 0);
        check("fill_count", fifo_count, DEPTH);
        check("fill_busy", busy, 1);
        char_valid = 1'b0;
        wait_idle("fill_drain");
        check("fill_queue_empty", exp_q.size(), 0);

        // Reset mid-frame during data bit 3
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hC3);
        // first accept edge N is 4 negedges back, so the line now sits in data bit 3
        repeat (14) @(negedge clock);
        check("midrst_pre_line", serial_out, 0);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_line", serial_out, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_ready", char_ready, 1);
        check("midrst_busy", busy, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        send_byte(8'hA5);
        check("post_rst_latency", serial_out, 1);
        mism = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            if (serial_out !== wave_bit(8'hA5, 8'h00, i)) mism++;
        end
        check("post_rst_wave", mism, 0);
        wait_idle("post_rst_idle");

        // ASCII string with random gaps
        msg = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        for (int i = 0; i < 26; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            send_byte(msg[i]);
        end
        wait_idle("ascii_idle");
        check("ascii_queue_empty", exp_q.size(), 0);

        // Random bytes with random gaps, sometimes idle long enough to drain
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, (i % 8 == 0) ? 60 : 6)) @(negedge clock);
            send_byte(8'($urandom_range(0, 255)));
        end
        wait_idle("rand_idle");
        check("rand_queue_empty", exp_q.size(), 0);
        check("final_line", serial_out, 1);
        check("final_count", fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
